bus_ctrl_fsm: RTL and testbench
===============================

Name: bus_ctrl_fsm

Overview:
Parametrised multi-bank bus interface controller for a multiplexed address/data bus with ALE, chip-select, and active-low read and write strobes.
- Latches the address and decodes a one-hot chip-select to a bank index.
- Inserts a programmable number of wait states, then issues a single-cycle output-enable or write-enable to the selected bank.
- Flags protocol errors and counts completed transfers.
- Sits between the external bus pins and the bank array; replaces the single-bank, zero-wait controller.

Parameters:
ADDR_W, 8, width of latched address taken from ad_in[ADDR_W-1:0]
DATA_W, 8, width of ad_in (ADDR_W <= DATA_W)
NUM_CS, 4, number of banks / chip-select lines (>= 1)
WAIT_CYC, 2, wait states between strobe detect and access (0 allowed)
START_TO, 15, max cycles in START without a strobe before timeout (>= 1)
CNT_W, 16, width of transfer counter

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
cs  in  NUM_CS  chip selects, one-hot when valid
ale  in  1  address latch enable
rdb  in  1  read strobe, active low
wrb  in  1  write strobe, active low
ad_in  in  DATA_W  multiplexed address/data bus
load  out  1  address-latch pulse, high for the single START entry cycle
addr_q  out  ADDR_W  latched address
bank_sel  out  $clog2(NUM_CS) or 1 if NUM_CS=1  latched bank index
oe  out  NUM_CS  one-hot read enable to selected bank
we  out  NUM_CS  one-hot write enable to selected bank
ready  out  1  high during the access cycle
busy  out  1  high whenever state != IDLE
err  out  1  one-cycle protocol error pulse
xfer_cnt  out  CNT_W  completed-transfer count, saturating

Behaviour:
- Reset (synchronous, active-high; clock is clock): state=IDLE; all outputs 0 (addr_q, bank_sel, xfer_cnt included); internal counters 0. Reset mid-transfer aborts with no oe/we pulse.
- States: IDLE, START, WAIT, READ, WRITE, TRISTATE. Registered state; outputs are decoded from the state plus the latched bank/op registers.
- IDLE:
  - ale=1 and cs exactly one-hot: capture addr_q <= ad_in[ADDR_W-1:0] and bank_sel <= index of the set bit, then go to START.
  - ale=1 and cs has two or more bits set: err=1 next cycle, stay in IDLE, addr_q unchanged.
  - cs=0: ignore.
- START:
  - load=1 only on the first START cycle.
  - wrb=0 and rdb=1: op=WRITE, go to WAIT. rdb=0 and wrb=1: op=READ, go to WAIT.
  - wrb=0 and rdb=0 in the same cycle: err pulse, go to TRISTATE, no access.
  - Neither strobe: stay in START and count cycles. After START_TO cycles in START without a strobe: err pulse, go to IDLE.
- WAIT:
  - Counter loads WAIT_CYC-1 on entry, decrements, and exits to READ or WRITE (per op) when it reaches 0. Exactly WAIT_CYC cycles are spent in WAIT.
  - WAIT_CYC=0: START goes directly to READ/WRITE and WAIT is never entered.
  - Strobes are not re-sampled in WAIT.
- READ: oe[bank_sel]=1 and ready=1 for exactly one cycle, then TRISTATE.
- WRITE: we[bank_sel]=1 and ready=1 for exactly one cycle, then TRISTATE.
- TRISTATE: all enables 0 for one cycle, then IDLE. ale in this cycle is ignored.
- Latency: from the strobe-detect cycle in START, the access cycle is WAIT_CYC+1 cycles later.
- oe and we are never both nonzero, and at most one bit is set in each.
- xfer_cnt increments by 1 on each READ/WRITE cycle and holds at 2^CNT_W-1. Error paths do not count.

Optional Feature:
BUS_CTRL_BURST_EN
- Defined: at the end of a READ/WRITE cycle, if the same strobe is still low and ale=0, addr_q increments by 1 (wraps 2^ADDR_W-1 -> 0), the FSM returns to WAIT (or directly to the access state if WAIT_CYC=0), and op and bank are unchanged. The burst ends when the strobe rises, and the FSM then goes to TRISTATE. Each beat increments xfer_cnt.
- Undefined: addr_q is never modified after latching; READ/WRITE always go to TRISTATE.

Test Plan:
- Single read, WAIT_CYC=2: ale=1, cs=4'b0100, ad_in=8'h3C; then rdb=0 in START -> load for 1 cycle, bank_sel=2, addr_q=8'h3C, oe=4'b0100 exactly 3 cycles after the strobe-detect cycle, then TRISTATE -> IDLE, xfer_cnt=1.
- Write with WAIT_CYC=0: cs=4'b0001, wrb=0 in START -> we=4'b0001 on the very next cycle, ready=1, oe stays 0.
- Errors:
  - cs=4'b0110 with ale=1 -> err pulse, busy stays 0.
  - rdb=0 and wrb=0 together in START -> err pulse, no oe/we, TRISTATE then IDLE.
- Timeout: enter START and hold rdb=wrb=1 for 15 cycles -> err pulse, IDLE, no access.
- Reset mid-WAIT: assert reset during the 2nd WAIT cycle -> next cycle all outputs 0, no oe/we ever asserted, xfer_cnt=0.
- Burst (BUS_CTRL_BURST_EN): addr 8'hFE, hold rdb=0 for 3 beats -> addr_q FE, FF, 00; three oe pulses to the same bank; xfer_cnt=3.

Source files
------------

// File: rtl/bus_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// bus_ctrl_fsm
// Multi-bank controller for a multiplexed address/data bus. It latches the
// address on ALE, decodes a one-hot chip select to a bank index, waits a fixed
// number of cycles after the strobe and then issues one single-cycle output
// enable (read) or write enable to the selected bank. Protocol errors produce
// a one-cycle err pulse and completed accesses are counted (saturating).
//
// Optional build macro: BUS_CTRL_BURST_EN
//   When defined, an access whose strobe is still low (with ale low) at the end
//   of the access cycle continues as a burst: addr_q increments (wrapping) and
//   another access to the same bank with the same direction follows.
//
// Ports:
//   clock     in   rising-edge clock
//   reset     in   synchronous, active-high reset
//   cs        in   [NUM_CS]  chip selects, valid when exactly one-hot
//   ale       in   address latch enable
//   rdb       in   read strobe, active low
//   wrb       in   write strobe, active low
//   ad_in     in   [DATA_W]  multiplexed address/data bus
//   load      out  high on the first START cycle only
//   addr_q    out  [ADDR_W]  latched address
//   bank_sel  out  [BANK_W]  latched bank index
//   oe        out  [NUM_CS]  one-hot read enable
//   we        out  [NUM_CS]  one-hot write enable
//   ready     out  high during the access cycle
//   busy      out  high whenever the FSM is not idle
//   err       out  one-cycle protocol error pulse
//   xfer_cnt  out  [CNT_W]   completed-transfer count, saturating
// -----------------------------------------------------------------------------
module bus_ctrl_fsm #(
    parameter int  ADDR_W   = 8,
    parameter int  DATA_W   = 8,
    parameter int  NUM_CS   = 4,
    parameter int  WAIT_CYC = 2,
    parameter int  START_TO = 15,
    parameter int  CNT_W    = 16,
    localparam int BANK_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CS-1:0] cs,
    input  logic              ale,
    input  logic              rdb,
    input  logic              wrb,
    input  logic [DATA_W-1:0] ad_in,
    output logic              load,
    output logic [ADDR_W-1:0] addr_q,
    output logic [BANK_W-1:0] bank_sel,
    output logic [NUM_CS-1:0] oe,
    output logic [NUM_CS-1:0] we,
    output logic              ready,
    output logic              busy,
    output logic              err,
    output logic [CNT_W-1:0]  xfer_cnt
);

    localparam int WAIT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam int ST_W   = (START_TO > 1) ? $clog2(START_TO) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD  = WAIT_W'((WAIT_CYC > 0) ? WAIT_CYC - 1 : 0);
    localparam logic [ST_W-1:0]   START_LAST = ST_W'(START_TO - 1);
    localparam logic [NUM_CS-1:0] CS_ONE     = NUM_CS'(1);
    localparam logic              NO_WAIT    = (WAIT_CYC == 0);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_WAIT     = 3'd2,
        ST_READ     = 3'd3,
        ST_WRITE    = 3'd4,
        ST_TRISTATE = 3'd5
    } state_t;

    state_t              state_r;
    state_t              next_state_s;
    logic                op_write_r;
    logic                op_write_s;
    logic [WAIT_W-1:0]   wait_cnt_r;
    logic [ST_W-1:0]     start_cnt_r;
    logic                capture_s;
    logic                err_set_s;
    logic                wait_load_s;
    logic                addr_inc_s;
    logic                cs_onehot_s;
    logic                cs_multi_s;
    logic [NUM_CS-1:0]   bank_dec_s;
    logic                unused_s;

    // Bit position of the (single) set bit of a chip-select vector.
    function automatic logic [BANK_W-1:0] cs_index(input logic [NUM_CS-1:0] sel);
        logic [BANK_W-1:0] idx;
        idx = {BANK_W{1'b0}};
        for (int i = 32'sd0; i < NUM_CS; i++) begin
            if (sel[i]) begin
                idx = BANK_W'(i);
            end
        end
        return idx;
    endfunction

    // Access state that matches the latched transfer direction.
    function automatic state_t access_state(input logic is_write);
        if (is_write) begin
            return ST_WRITE;
        end else begin
            return ST_READ;
        end
    endfunction

    // Only the low ADDR_W bits of the bus carry the address.
    assign unused_s = ^ad_in;

    // Chip-select classification: exactly one bit versus two or more.
    always_comb begin
        cs_onehot_s = (cs != {NUM_CS{1'b0}}) &&
                      ((cs & (cs - CS_ONE)) == {NUM_CS{1'b0}});
        cs_multi_s  = (cs != {NUM_CS{1'b0}}) && !cs_onehot_s;
    end

    // Next-state logic and the per-cycle control decisions that go with it.
    always_comb begin
        next_state_s = state_r;
        op_write_s   = op_write_r;
        capture_s    = 1'b0;
        err_set_s    = 1'b0;
        wait_load_s  = 1'b0;
        addr_inc_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ale && cs_onehot_s) begin
                    capture_s    = 1'b1;
                    next_state_s = ST_START;
                end else if (ale && cs_multi_s) begin
                    err_set_s    = 1'b1;
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (!rdb && !wrb) begin
                    // Conflicting strobes: release the bus without an access.
                    err_set_s    = 1'b1;
                    next_state_s = ST_TRISTATE;
                end else if (!rdb || !wrb) begin
                    op_write_s   = !wrb;
                    wait_load_s  = !NO_WAIT;
                    next_state_s = NO_WAIT ? access_state(!wrb) : ST_WAIT;
                end else if (start_cnt_r == START_LAST) begin
                    err_set_s    = 1'b1;
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_START;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r == {WAIT_W{1'b0}}) begin
                    next_state_s = access_state(op_write_r);
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_READ, ST_WRITE: begin
`ifdef BUS_CTRL_BURST_EN
                // Same strobe still held low and no new address: next beat.
                if (!ale && (op_write_r ? !wrb : !rdb)) begin
                    addr_inc_s   = 1'b1;
                    wait_load_s  = !NO_WAIT;
                    next_state_s = NO_WAIT ? access_state(op_write_r) : ST_WAIT;
                end else begin
                    next_state_s = ST_TRISTATE;
                end
`else
                next_state_s = ST_TRISTATE;
`endif
            end
            ST_TRISTATE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register plus the START dwell counter and WAIT down-counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            op_write_r  <= 1'b0;
            start_cnt_r <= {ST_W{1'b0}};
            wait_cnt_r  <= {WAIT_W{1'b0}};
        end else begin
            state_r    <= next_state_s;
            op_write_r <= op_write_s;
            if ((state_r == ST_START) && (next_state_s == ST_START)) begin
                start_cnt_r <= start_cnt_r + ST_W'(1);
            end else begin
                start_cnt_r <= {ST_W{1'b0}};
            end
            if (wait_load_s) begin
                wait_cnt_r <= WAIT_LOAD;
            end else if ((state_r == ST_WAIT) && (wait_cnt_r != {WAIT_W{1'b0}})) begin
                wait_cnt_r <= wait_cnt_r - WAIT_W'(1);
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
        end
    end

    // Latched address and bank, registered error pulse, transfer counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q   <= {ADDR_W{1'b0}};
            bank_sel <= {BANK_W{1'b0}};
            err      <= 1'b0;
            xfer_cnt <= {CNT_W{1'b0}};
        end else begin
            err <= err_set_s;
            if (capture_s) begin
                addr_q   <= ad_in[ADDR_W-1:0];
                bank_sel <= cs_index(cs);
            end else if (addr_inc_s) begin
                addr_q <= addr_q + ADDR_W'(1);
            end
            if (((state_r == ST_READ) || (state_r == ST_WRITE)) &&
                (xfer_cnt != {CNT_W{1'b1}})) begin
                xfer_cnt <= xfer_cnt + CNT_W'(1);
            end
        end
    end

    // Output decode from the registered state and latched bank.
    always_comb begin
        bank_dec_s = CS_ONE << bank_sel;
        oe         = {NUM_CS{1'b0}};
        we         = {NUM_CS{1'b0}};
        ready      = 1'b0;
        busy       = (state_r != ST_IDLE);
        load       = (state_r == ST_START) && (start_cnt_r == {ST_W{1'b0}});
        case (state_r)
            ST_READ: begin
                oe    = bank_dec_s;
                ready = 1'b1;
            end
            ST_WRITE: begin
                we    = bank_dec_s;
                ready = 1'b1;
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_bus_ctrl_fsm
// Self-checking bench for bus_ctrl_fsm. Two instances share one stimulus set:
// dut_a uses WAIT_CYC=2, dut_b uses WAIT_CYC=0. use_b selects which one sees
// live inputs (the other is held idle) and which one the m_* view shows.
// Expected values come from a transaction-level timeline: a transfer whose
// strobe is seen in START interval s has its access at s + WAIT_CYC + 1.
// -----------------------------------------------------------------------------
module tb_bus_ctrl_fsm;

    localparam int START_TO = 15;

    logic        clock;
    logic        reset;
    logic [3:0]  cs;
    logic        ale;
    logic        rdb;
    logic        wrb;
    logic [7:0]  ad_in;
    logic        use_b;

    logic        a_load, a_ready, a_busy, a_err;
    logic [7:0]  a_addr_q;
    logic [1:0]  a_bank_sel;
    logic [3:0]  a_oe, a_we;
    logic [15:0] a_xfer_cnt;
    logic        b_load, b_ready, b_busy, b_err;
    logic [7:0]  b_addr_q;
    logic [1:0]  b_bank_sel;
    logic [3:0]  b_oe, b_we;
    logic [15:0] b_xfer_cnt;

    logic        m_load, m_ready, m_busy, m_err;
    logic [7:0]  m_addr_q;
    logic [1:0]  m_bank_sel;
    logic [3:0]  m_oe, m_we;
    logic [15:0] m_xfer_cnt;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cnt_model [2];
    logic [7:0]  last_addr [2];

    bus_ctrl_fsm #(.ADDR_W(8), .DATA_W(8), .NUM_CS(4), .WAIT_CYC(2),
                   .START_TO(START_TO), .CNT_W(16)) dut_a (
        .clock(clock), .reset(reset),
        .cs(use_b ? 4'b0000 : cs), .ale(use_b ? 1'b0 : ale),
        .rdb(use_b ? 1'b1 : rdb), .wrb(use_b ? 1'b1 : wrb), .ad_in(ad_in),
        .load(a_load), .addr_q(a_addr_q), .bank_sel(a_bank_sel), .oe(a_oe),
        .we(a_we), .ready(a_ready), .busy(a_busy), .err(a_err),
        .xfer_cnt(a_xfer_cnt));

    bus_ctrl_fsm #(.ADDR_W(8), .DATA_W(8), .NUM_CS(4), .WAIT_CYC(0),
                   .START_TO(START_TO), .CNT_W(16)) dut_b (
        .clock(clock), .reset(reset),
        .cs(use_b ? cs : 4'b0000), .ale(use_b ? ale : 1'b0),
        .rdb(use_b ? rdb : 1'b1), .wrb(use_b ? wrb : 1'b1), .ad_in(ad_in),
        .load(b_load), .addr_q(b_addr_q), .bank_sel(b_bank_sel), .oe(b_oe),
        .we(b_we), .ready(b_ready), .busy(b_busy), .err(b_err),
        .xfer_cnt(b_xfer_cnt));

    assign m_load     = use_b ? b_load     : a_load;
    assign m_ready    = use_b ? b_ready    : a_ready;
    assign m_busy     = use_b ? b_busy     : a_busy;
    assign m_err      = use_b ? b_err      : a_err;
    assign m_addr_q   = use_b ? b_addr_q   : a_addr_q;
    assign m_bank_sel = use_b ? b_bank_sel : a_bank_sel;
    assign m_oe       = use_b ? b_oe       : a_oe;
    assign m_we       = use_b ? b_we       : a_we;
    assign m_xfer_cnt = use_b ? b_xfer_cnt : a_xfer_cnt;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        ale = 1'b0; cs = 4'b0000; rdb = 1'b1; wrb = 1'b1; ad_in = 8'($urandom);
    endtask

    // One complete transfer starting from an IDLE interval. dly = START
    // cycles without a strobe before the strobe is presented.
    task automatic run_xfer(input int bank, input logic [7:0] addr, input bit wr, input int dly);
        int          wcyc, acc, d;
        logic [3:0]  dec, exp_oe, exp_we;
        logic [15:0] exp_cnt;
        wcyc = use_b ? 0 : 2;
        d    = use_b ? 1 : 0;
        dec  = 4'b0001 << bank;
        acc  = 1 + dly + wcyc + 1;
        ale = 1'b1; cs = dec; ad_in = addr; rdb = 1'b1; wrb = 1'b1;
        for (int t = 1; t <= acc + 2; t++) begin
            tick();
            exp_oe  = (t == acc && !wr) ? dec : 4'b0000;
            exp_we  = (t == acc && wr) ? dec : 4'b0000;
            exp_cnt = 16'(cnt_model[d] + ((t > acc) ? 1 : 0));
            if (m_oe !== exp_oe || m_we !== exp_we) begin
                $display("FAIL xfer_enable t=%0d oe=%b we=%b expected oe=%b we=%b", t, m_oe, m_we, exp_oe, exp_we);
                n_errors++;
            end
            n_checks++;
            if (m_ready !== (t == acc)) begin
                $display("FAIL xfer_ready t=%0d got %b expected %b", t, m_ready, (t == acc));
                n_errors++;
            end
            n_checks++;
            if (m_load !== (t == 1)) begin
                $display("FAIL xfer_load t=%0d got %b expected %b", t, m_load, (t == 1));
                n_errors++;
            end
            n_checks++;
            if (m_busy !== (t <= acc + 1)) begin
                $display("FAIL xfer_busy t=%0d got %b expected %b", t, m_busy, (t <= acc + 1));
                n_errors++;
            end
            n_checks++;
            if (m_err !== 1'b0) begin
                $display("FAIL xfer_err t=%0d got %b expected 0", t, m_err);
                n_errors++;
            end
            n_checks++;
            if (m_addr_q !== addr || m_bank_sel !== 2'(bank)) begin
                $display("FAIL xfer_latch t=%0d addr=%h bank=%0d expected addr=%h bank=%0d", t, m_addr_q, m_bank_sel, addr, bank);
                n_errors++;
            end
            n_checks++;
            if (m_xfer_cnt !== exp_cnt) begin
                $display("FAIL xfer_cnt t=%0d got %0d expected %0d", t, m_xfer_cnt, exp_cnt);
                n_errors++;
            end
            n_checks++;
            // Stimulus for the interval just entered; ignored inputs are randomised.
            ale = 1'($urandom); cs = 4'($urandom); ad_in = 8'($urandom); rdb = 1'b1; wrb = 1'b1;
            if (t <= dly) begin
                ale = 1'($urandom);
            end else if (t == dly + 1) begin
                rdb = wr; wrb = !wr;
            end else if (t < acc) begin
                rdb = 1'($urandom); wrb = 1'($urandom);
            end else if (t == acc) begin
                ale = 1'b0;
            end else if (t == acc + 1) begin
                ale = 1'b1; cs = 4'b0001 << $urandom_range(3, 0);
            end else begin
                idle_inputs();
            end
        end
        cnt_model[d]++;
        last_addr[d] = addr;
    endtask

    task automatic test_reset();
        use_b = 1'b0; ale = 1'b1; cs = 4'b0100; rdb = 1'b0; wrb = 1'b1; ad_in = 8'hA5;
        reset = 1'b1;
        tick(); tick();
        if ({a_load, a_addr_q, a_bank_sel, a_oe, a_we, a_ready, a_busy, a_err, a_xfer_cnt} !== 38'd0) begin
            $display("FAIL reset_a outputs=%h expected 0", {a_load, a_addr_q, a_bank_sel, a_oe, a_we, a_ready, a_busy, a_err, a_xfer_cnt});
            n_errors++;
        end
        n_checks++;
        if ({b_load, b_addr_q, b_bank_sel, b_oe, b_we, b_ready, b_busy, b_err, b_xfer_cnt} !== 38'd0) begin
            $display("FAIL reset_b outputs=%h expected 0", {b_load, b_addr_q, b_bank_sel, b_oe, b_we, b_ready, b_busy, b_err, b_xfer_cnt});
            n_errors++;
        end
        n_checks++;
        idle_inputs();
        reset = 1'b0;
        cnt_model[0] = 0; cnt_model[1] = 0; last_addr[0] = 8'h00; last_addr[1] = 8'h00;
        tick();
        if (a_busy !== 1'b0 || a_addr_q !== 8'h00) begin
            $display("FAIL reset_idle busy=%b addr=%h expected busy=0 addr=00", a_busy, a_addr_q);
            n_errors++;
        end
        n_checks++;
    endtask

    task automatic test_single_read();
        use_b = 1'b0;
        run_xfer(2, 8'h3C, 1'b0, 0);
        if (a_xfer_cnt !== 16'd1) begin
            $display("FAIL single_read_cnt got %0d expected 1", a_xfer_cnt);
            n_errors++;
        end
        n_checks++;
    endtask

    task automatic test_write_nowait();
        use_b = 1'b1;
        run_xfer(0, 8'($urandom), 1'b1, 0);
        run_xfer(3, 8'($urandom), 1'b0, 3);
        use_b = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            use_b = 1'b0;
            run_xfer($urandom_range(3, 0), 8'($urandom), 1'($urandom), $urandom_range(START_TO - 1, 0));
        end
        for (int n = 0; n < 8; n++) begin
            use_b = 1'b1;
            run_xfer($urandom_range(3, 0), 8'($urandom), 1'($urandom), $urandom_range(START_TO - 1, 0));
        end
        use_b = 1'b0;
    endtask

    task automatic test_back_to_back();
        use_b = 1'b0;
        run_xfer(1, 8'h10, 1'b1, 0);
        run_xfer(1, 8'h11, 1'b0, 0);
        run_xfer(3, 8'hFF, 1'b1, START_TO - 1);
        run_xfer(0, 8'h00, 1'b0, START_TO - 1);
    endtask

    task automatic test_errors();
        use_b = 1'b0;
        ale = 1'b1; cs = 4'b0110; ad_in = 8'h55;
        tick();
        if (a_err !== 1'b1 || a_busy !== 1'b0 || a_addr_q !== last_addr[0]) begin
            $display("FAIL multi_cs err=%b busy=%b addr=%h expected err=1 busy=0 addr=%h", a_err, a_busy, a_addr_q, last_addr[0]);
            n_errors++;
        end
        n_checks++;
        ale = 1'b1; cs = 4'b0000;
        tick();
        if (a_err !== 1'b0 || a_busy !== 1'b0) begin
            $display("FAIL no_cs err=%b busy=%b expected err=0 busy=0", a_err, a_busy);
            n_errors++;
        end
        n_checks++;
        ale = 1'b1; cs = 4'b1000; ad_in = 8'hA7;
        tick();
        rdb = 1'b0; wrb = 1'b0; ale = 1'b0;
        tick();
        if (a_err !== 1'b1 || a_busy !== 1'b1 || a_oe !== 4'b0000 || a_we !== 4'b0000) begin
            $display("FAIL both_strobes err=%b busy=%b oe=%b we=%b expected err=1 busy=1 oe=0 we=0", a_err, a_busy, a_oe, a_we);
            n_errors++;
        end
        n_checks++;
        idle_inputs();
        tick();
        if (a_err !== 1'b0 || a_busy !== 1'b0 || a_xfer_cnt !== 16'(cnt_model[0]) || a_oe !== 4'b0000 || a_we !== 4'b0000) begin
            $display("FAIL both_strobes_end err=%b busy=%b cnt=%0d expected err=0 busy=0 cnt=%0d", a_err, a_busy, a_xfer_cnt, cnt_model[0]);
            n_errors++;
        end
        n_checks++;
        last_addr[0] = 8'hA7;
    endtask

    task automatic test_timeout();
        use_b = 1'b0;
        ale = 1'b1; cs = 4'b0010; ad_in = 8'h6D;
        for (int t = 1; t <= START_TO + 2; t++) begin
            tick();
            ale = 1'b0; rdb = 1'b1; wrb = 1'b1;
            if (m_busy !== (t <= START_TO) || m_err !== (t == START_TO + 1) || m_oe !== 4'b0000 || m_we !== 4'b0000) begin
                $display("FAIL timeout t=%0d busy=%b err=%b oe=%b we=%b expected busy=%b err=%b", t, m_busy, m_err, m_oe, m_we, (t <= START_TO), (t == START_TO + 1));
                n_errors++;
            end
            n_checks++;
        end
        last_addr[0] = 8'h6D;
    endtask

    task automatic test_burst();
        int          beats, nb, last_acc;
        bit          is_acc;
        logic [7:0]  exp_addr;
`ifdef BUS_CTRL_BURST_EN
        beats = 3;
`else
        beats = 1;
`endif
        use_b = 1'b0;
        last_acc = 4 + 3 * (beats - 1);
        ale = 1'b1; cs = 4'b0010; ad_in = 8'hFE; rdb = 1'b1; wrb = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            is_acc   = (t >= 4) && ((t - 4) % 3 == 0) && ((t - 4) / 3 < beats);
            nb       = (t <= 4) ? 0 : (((t - 5) / 3 + 1 < beats) ? (t - 5) / 3 + 1 : beats);
            exp_addr = 8'(8'hFE + ((nb < beats - 1) ? nb : beats - 1));
            if (m_oe !== (is_acc ? 4'b0010 : 4'b0000) || m_we !== 4'b0000) begin
                $display("FAIL burst_oe t=%0d oe=%b we=%b expected oe=%b we=0000", t, m_oe, m_we, (is_acc ? 4'b0010 : 4'b0000));
                n_errors++;
            end
            n_checks++;
            if (m_addr_q !== exp_addr || m_busy !== (t <= last_acc + 1)) begin
                $display("FAIL burst_addr t=%0d addr=%h busy=%b expected addr=%h busy=%b", t, m_addr_q, m_busy, exp_addr, (t <= last_acc + 1));
                n_errors++;
            end
            n_checks++;
            if (m_xfer_cnt !== 16'(cnt_model[0] + nb)) begin
                $display("FAIL burst_cnt t=%0d got %0d expected %0d", t, m_xfer_cnt, cnt_model[0] + nb);
                n_errors++;
            end
            n_checks++;
            ale = 1'b0; cs = 4'($urandom); wrb = 1'b1;
            rdb = (t <= 9) ? 1'b0 : 1'b1;
        end
        cnt_model[0] += beats;
        last_addr[0] = 8'(8'hFE + beats - 1);
    endtask

    task automatic test_reset_mid_wait();
        use_b = 1'b0;
        ale = 1'b1; cs = 4'b0010; ad_in = 8'h99;
        tick();
        ale = 1'b0; rdb = 1'b0; wrb = 1'b1;
        tick();
        rdb = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        if ({a_load, a_addr_q, a_bank_sel, a_oe, a_we, a_ready, a_busy, a_err, a_xfer_cnt} !== 38'd0) begin
            $display("FAIL reset_mid_wait outputs=%h expected 0", {a_load, a_addr_q, a_bank_sel, a_oe, a_we, a_ready, a_busy, a_err, a_xfer_cnt});
            n_errors++;
        end
        n_checks++;
        reset = 1'b0; idle_inputs();
        cnt_model[0] = 0; cnt_model[1] = 0; last_addr[0] = 8'h00; last_addr[1] = 8'h00;
        for (int t = 0; t < 4; t++) begin
            tick();
            if (a_oe !== 4'b0000 || a_we !== 4'b0000 || a_busy !== 1'b0 || a_xfer_cnt !== 16'd0) begin
                $display("FAIL after_reset t=%0d oe=%b we=%b busy=%b cnt=%0d expected all 0", t, a_oe, a_we, a_busy, a_xfer_cnt);
                n_errors++;
            end
            n_checks++;
        end
    endtask

    initial begin
        use_b = 1'b0;
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_single_read();
        test_write_nowait();
        test_random();
        test_back_to_back();
        test_errors();
        test_timeout();
        test_burst();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
